// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads 16-bit words over a ready/valid
// handshake, and strobes them into the IR. Redirects during a fetch are deferred.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int          TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic [15:0] Instruction,
    output logic        ir_enable,
    output logic [4:0]  opcode_early,
    output logic [15:0] PC,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        pend_vld;
    logic [15:0] pend_pc;
    logic [15:0] eff_pc;

    // A same-edge redirect applies to the fetch being launched.
    assign eff_pc       = pc_load ? pc_target : PC;
    assign opcode_early = Instruction[15:11];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            mem_addr    <= RESET_PC;
            mem_rd      <= 1'b0;
            Instruction <= 16'h0000;
            ir_enable   <= 1'b0;
            busy        <= 1'b0;
            fetch_err   <= 1'b0;
            pend_vld    <= 1'b0;
            pend_pc     <= 16'h0000;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_load) PC <= pc_target;
                    if (fetch_req) begin
                        mem_addr <= eff_pc;
                        mem_rd   <= 1'b1;
                        wait_cnt <= 8'd0;
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        Instruction <= mem_data;
                        ir_enable   <= 1'b1;
                        mem_rd      <= 1'b0;
                        pend_vld    <= 1'b0;
                        if (pc_load)       PC <= pc_target;
                        else if (pend_vld) PC <= pend_pc;
                        else               PC <= PC + PC_STEP;
                        state <= DONE;
                    end else begin
                        if (pc_load) begin
                            pend_vld <= 1'b1;
                            pend_pc  <= pc_target;
                        end
                        wait_cnt <= wait_cnt + 8'd1;
                        // Abort leaves PC, IR and any pending redirect intact.
                        if (wait_cnt + 8'd1 == TO_LIM) begin
                            mem_rd    <= 1'b0;
                            fetch_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                DONE: begin
                    ir_enable <= 1'b0;
                    if (pc_load) PC <= pc_target;
                    if (fetch_req) begin
                        mem_addr <= eff_pc;
                        mem_rd   <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: each task drives one scenario and
// compares outputs against hand-derived values one time unit after the edge.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [15:0] Instruction;
    logic        ir_enable;
    logic [4:0]  opcode_early;
    logic [15:0] PC;
    logic        busy;
    logic        fetch_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    instruction_fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_target(pc_target), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .mem_ready(mem_ready), .Instruction(Instruction),
        .ir_enable(ir_enable), .opcode_early(opcode_early), .PC(PC),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; tick(); Reset = 1'b0;
        total_cnt++; if (PC !== 16'h0000) $display("FAIL reset_pc got %h exp 0000", PC); else pass_cnt++;
        total_cnt++; if (mem_addr !== 16'h0000) $display("FAIL reset_addr got %h exp 0000", mem_addr); else pass_cnt++;
        total_cnt++; if ({mem_rd, ir_enable, busy, fetch_err} !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", {mem_rd, ir_enable, busy, fetch_err}); else pass_cnt++;
        total_cnt++; if (Instruction !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", Instruction); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        fetch_req = 1'b1; tick();                            // edge 1
        total_cnt++; if ({mem_rd, busy} !== 2'b11 || mem_addr !== 16'h0000) $display("FAIL b2b_req1 got rd=%b busy=%b addr=%h exp 1 1 0000", mem_rd, busy, mem_addr); else pass_cnt++;
        mem_ready = 1'b1; mem_data = 16'hA803; tick();       // edge 2
        total_cnt++; if (Instruction !== 16'hA803 || ir_enable !== 1'b1) $display("FAIL b2b_ir1 got %h en=%b exp a803 1", Instruction, ir_enable); else pass_cnt++;
        total_cnt++; if (opcode_early !== 5'h15) $display("FAIL b2b_opcode got %h exp 15", opcode_early); else pass_cnt++;
        total_cnt++; if (PC !== 16'h0002 || mem_rd !== 1'b0) $display("FAIL b2b_pc1 got %h rd=%b exp 0002 0", PC, mem_rd); else pass_cnt++;
        mem_ready = 1'b0; tick();                            // edge 3
        total_cnt++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0002 || ir_enable !== 1'b0) $display("FAIL b2b_req2 got rd=%b addr=%h en=%b exp 1 0002 0", mem_rd, mem_addr, ir_enable); else pass_cnt++;
        mem_ready = 1'b1; mem_data = 16'h1234; tick();       // edge 4
        total_cnt++; if (Instruction !== 16'h1234 || ir_enable !== 1'b1 || PC !== 16'h0004) $display("FAIL b2b_ir2 got %h en=%b pc=%h exp 1234 1 0004", Instruction, ir_enable, PC); else pass_cnt++;
        mem_ready = 1'b0; fetch_req = 1'b0; tick();          // back to IDLE
        total_cnt++; if ({ir_enable, busy, mem_rd} !== 3'b000) $display("FAIL b2b_idle got %b exp 000", {ir_enable, busy, mem_rd}); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        int pulses = 0;
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ir_enable) pulses++;
            total_cnt++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0004) $display("FAIL ws_hold%0d got rd=%b addr=%h exp 1 0004", i, mem_rd, mem_addr); else pass_cnt++;
        end
        mem_ready = 1'b1; mem_data = 16'h5555; tick();
        if (ir_enable) pulses++;
        total_cnt++; if (PC !== 16'h0006 || Instruction !== 16'h5555) $display("FAIL ws_done got pc=%h ir=%h exp 0006 5555", PC, Instruction); else pass_cnt++;
        mem_ready = 1'b0; tick();
        if (ir_enable) pulses++;
        total_cnt++; if (pulses !== 1 || PC !== 16'h0006) $display("FAIL ws_pulses got %0d pc=%h exp 1 0006", pulses, PC); else pass_cnt++;
    endtask

    task automatic test_redirect();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        pc_load = 1'b1; pc_target = 16'h0100; tick(); pc_load = 1'b0;
        total_cnt++; if (PC !== 16'h0006 || mem_addr !== 16'h0006) $display("FAIL rd_pend got pc=%h addr=%h exp 0006 0006", PC, mem_addr); else pass_cnt++;
        mem_ready = 1'b1; mem_data = 16'h7777; tick(); mem_ready = 1'b0;
        total_cnt++; if (PC !== 16'h0100) $display("FAIL rd_pc got %h exp 0100", PC); else pass_cnt++;
        tick();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        total_cnt++; if (mem_addr !== 16'h0100) $display("FAIL rd_addr got %h exp 0100", mem_addr); else pass_cnt++;
        mem_ready = 1'b1; mem_data = 16'h2222; tick(); mem_ready = 1'b0;
        total_cnt++; if (PC !== 16'h0102) $display("FAIL rd_next got %h exp 0102", PC); else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_target = 16'hFFFE; tick(); pc_load = 1'b0;
        total_cnt++; if (PC !== 16'hFFFE) $display("FAIL wrap_load got %h exp fffe", PC); else pass_cnt++;
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        total_cnt++; if (mem_addr !== 16'hFFFE) $display("FAIL wrap_addr got %h exp fffe", mem_addr); else pass_cnt++;
        mem_ready = 1'b1; mem_data = 16'h0F0F; tick(); mem_ready = 1'b0;
        total_cnt++; if (PC !== 16'h0000) $display("FAIL wrap_pc got %h exp 0000", PC); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 1; i < 15; i++) begin
            tick();
            if (ir_enable) pulses++;
            total_cnt++; if (mem_rd !== 1'b1) $display("FAIL to_hold%0d got rd=%b exp 1", i, mem_rd); else pass_cnt++;
        end
        tick();
        if (ir_enable) pulses++;
        total_cnt++; if (mem_rd !== 1'b0 || fetch_err !== 1'b1 || busy !== 1'b0) $display("FAIL to_abort got rd=%b err=%b busy=%b exp 0 1 0", mem_rd, fetch_err, busy); else pass_cnt++;
        total_cnt++; if (PC !== 16'h0000 || Instruction !== 16'h0F0F || pulses !== 0) $display("FAIL to_keep got pc=%h ir=%h pulses=%0d exp 0000 0f0f 0", PC, Instruction, pulses); else pass_cnt++;
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        mem_ready = 1'b1; mem_data = 16'hBEEF; tick(); mem_ready = 1'b0;
        total_cnt++; if (Instruction !== 16'hBEEF || PC !== 16'h0002 || fetch_err !== 1'b1) $display("FAIL to_recover got ir=%h pc=%h err=%b exp beef 0002 1", Instruction, PC, fetch_err); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        mem_ready = 1'b1; mem_data = 16'hDEAD; Reset = 1'b1; tick();
        Reset = 1'b0; mem_ready = 1'b0;
        total_cnt++; if ({mem_rd, ir_enable, busy, fetch_err} !== 4'b0000) $display("FAIL rst_mid_flags got %b exp 0000", {mem_rd, ir_enable, busy, fetch_err}); else pass_cnt++;
        total_cnt++; if (Instruction !== 16'h0000 || PC !== 16'h0000 || mem_addr !== 16'h0000) $display("FAIL rst_mid_regs got ir=%h pc=%h addr=%h exp 0000 0000 0000", Instruction, PC, mem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (ir_enable !== 1'b0 || Instruction !== 16'h0000) $display("FAIL rst_mid_after got en=%b ir=%h exp 0 0000", ir_enable, Instruction); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_redirect();
        test_wrap();
        test_timeout();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch unit for the accumulator processor: owns the program counter, reads 16-bit instruction words from instruction memory over a ready/valid-style read handshake, and writes each fetched word into the instruction register. It drives the IR's `Instruction` bus and `enable` strobe. It also exposes the opcode field `[15:11]` early so the control unit can start decoding. Fetches are started by the control unit and can be redirected by branch/jump PC loads.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value after reset
- `PC_STEP`, 2, PC increment per completed fetch (byte-addressed, 16-bit words)
- `TIMEOUT`, 15, max wait-state edges before a fetch is aborted (legal 1..255)

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `fetch_req`  in  1  control unit requests the next instruction; level, sampled each edge
- `pc_load`  in  1  redirect PC to `pc_target`
- `pc_target`  in  16  branch/jump target
- `mem_addr`  out  16  instruction memory address
- `mem_rd`  out  1  read request to memory
- `mem_data`  in  16  read data, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the read this edge
- `Instruction`  out  16  fetched word, to IR data input
- `ir_enable`  out  1  one-cycle IR write strobe
- `opcode_early`  out  5  `Instruction[15:11]` of the held word
- `PC`  out  16  current program counter
- `busy`  out  1  fetch in progress (state WAIT or DONE)
- `fetch_err`  out  1  sticky timeout flag

## Operation
- Reset (any state, any cycle, including mid-fetch) sets the following after the edge: state IDLE; `PC`=`mem_addr`=`RESET_PC`; `mem_rd`=0; `Instruction`=0; `ir_enable`=0; `busy`=0; `fetch_err`=0; pending redirect cleared; timeout counter=0. An in-flight read is abandoned, and no `ir_enable` is produced for it.
- States are IDLE, WAIT and DONE. All outputs are registered.
- IDLE:
  - `pc_load`=1 sets `PC`<=`pc_target`.
  - `fetch_req`=1 sets `mem_addr`<=effective PC and `mem_rd`<=1, then goes to WAIT. The effective PC is `pc_target` if `pc_load` is also 1, otherwise `PC`.
- WAIT:
  - `mem_addr` and `mem_rd` are held stable.
  - `mem_ready`=1: `Instruction`<=`mem_data`, `ir_enable`<=1, `mem_rd`<=0, and the state goes to DONE. `PC`<=pending redirect target if one is pending, otherwise `PC`+`PC_STEP` modulo 2^16 (wraps silently). Pending redirect is cleared.
  - `mem_ready`=0: the counter increments. When the counter reaches `TIMEOUT`, the fetch aborts: `mem_rd`<=0, `fetch_err`<=1, `PC` unchanged, no `ir_enable`, state goes to IDLE, pending redirect is retained.
  - `pc_load`=1 stores `pc_target` as pending; the last one wins. If `pc_load` and `mem_ready` arrive on the same edge, `PC`<=this `pc_target`.
- DONE:
  - `ir_enable`<=0.
  - `fetch_req`=1 starts the next fetch directly: `mem_rd`<=1, `mem_addr`<=effective PC, go to WAIT.
  - Otherwise go to IDLE. `pc_load` is handled as in IDLE.
- `fetch_req` while in WAIT is ignored. No queueing.
- `Instruction` and `opcode_early` hold the last fetched word until the next completed fetch. They are not altered by a timeout.
- `fetch_err` is cleared only by `Reset`. Fetching continues normally after an error.
- The counter resets to 0 on every entry to WAIT.

## Timing
- `fetch_req` sampled at edge N gives `mem_rd`=1 after N.
- `mem_ready` sampled at edge M gives `Instruction`/`ir_enable`/`PC` updated after M; `ir_enable` falls after M+1.
- With zero-wait memory (`mem_ready`=1 at N+1), `ir_enable` is high between edges N+1 and N+2, so latency from request to IR strobe is 2 edges.
- Back-to-back with `fetch_req` held high and zero-wait memory gives one instruction every 2 edges.
- A timeout fires at the `TIMEOUT`-th consecutive WAIT edge with `mem_ready`=0. With the default, `mem_rd` drops after edge N+15.
- `busy` is 1 in WAIT and DONE.

## Test plan
- Reset, hold `fetch_req`=1, zero-wait memory returning 16'hA803 then 16'h1234 -> `mem_addr` 0 then 2. `Instruction`=A803 with `opcode_early`=5'h15, then 1234. `ir_enable` pulses at edges 2 and 4. `PC`=4.
- Memory inserts 3 wait states -> `mem_rd`/`mem_addr` stable for 4 edges, single `ir_enable` pulse, `PC`+=2 once.
- `pc_load`=1 with `pc_target`=16'h0100 during WAIT, then `mem_ready` -> `PC`=0100, not old PC+2. The next `mem_addr`=0100.
- `PC`=16'hFFFE, fetch completes -> `PC`=16'h0000.
- `mem_ready` never asserted -> `mem_rd` drops after 15 WAIT edges, `fetch_err`=1, `PC` and `Instruction` unchanged, no `ir_enable`. The next fetch succeeds and `fetch_err` stays 1.
- `Reset` asserted in WAIT with `mem_ready`=1 on the same edge -> all outputs at reset values, no `ir_enable`, `Instruction`=0.
